// File: rtl/cbl_pkg.sv
// ---------------------------------------------------------------------------
// cbl_pkg -- shared types and constants for the core's pipeline control blocks.
//   hzd_state_t : hazard controller FSM states.
//   REG_ZERO    : index of the hard-wired zero register (never a hazard source).
//   BUB_CNT_W   : width of the load-use bubble down-counter (LOAD_BUBBLES <= 7).
//   hzd_ctrl_t  : bundle of per-stage stall/bubble/flush controls, for
//                 pipeline-register consumers.
// ---------------------------------------------------------------------------
package cbl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MC_WAIT   = 2'd2
  } hzd_state_t;

  localparam int REG_ZERO  = 0;
  localparam int BUB_CNT_W = 3;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic bubble_e;
    logic bubble_m;
    logic bubble_w;
    logic flush_d;
  } hzd_ctrl_t;

endpackage

// File: rtl/hzd_ctrl_if.sv
// ---------------------------------------------------------------------------
// hzd_ctrl_if -- signal bundle between the pipeline and the hazard controller.
//   master : pipeline side; drives the i_* hazard sources, reads the o_* controls.
//   slave  : hazard controller side.
// Parameters REG_SELECT / CNT_WIDTH must match the attached hzd_ctrl.
// ---------------------------------------------------------------------------
interface hzd_ctrl_if #(
  parameter int REG_SELECT = 5,
  parameter int CNT_WIDTH  = 32
);

  logic [REG_SELECT-1:0] i_reg_a_select_D;
  logic [REG_SELECT-1:0] i_reg_b_select_D;
  logic                  i_use_a_D;
  logic                  i_use_b_D;
  logic                  i_is_write_E;
  logic                  i_is_load_E;
  logic [REG_SELECT-1:0] i_reg_c_select_E;
  logic                  i_mc_start_E;
  logic                  i_mc_done;
  logic                  i_mem_busy;
  logic                  i_branch_taken_E;

  logic                  o_stall_F;
  logic                  o_stall_D;
  logic                  o_stall_E;
  logic                  o_stall_M;
  logic                  o_bubble_E;
  logic                  o_bubble_M;
  logic                  o_bubble_W;
  logic                  o_flush_D;
  logic                  o_mc_busy;
  logic [CNT_WIDTH-1:0]  o_stall_cnt;

  modport master (
    output i_reg_a_select_D, i_reg_b_select_D, i_use_a_D, i_use_b_D,
           i_is_write_E, i_is_load_E, i_reg_c_select_E,
           i_mc_start_E, i_mc_done, i_mem_busy, i_branch_taken_E,
    input  o_stall_F, o_stall_D, o_stall_E, o_stall_M,
           o_bubble_E, o_bubble_M, o_bubble_W, o_flush_D,
           o_mc_busy, o_stall_cnt
  );

  modport slave (
    input  i_reg_a_select_D, i_reg_b_select_D, i_use_a_D, i_use_b_D,
           i_is_write_E, i_is_load_E, i_reg_c_select_E,
           i_mc_start_E, i_mc_done, i_mem_busy, i_branch_taken_E,
    output o_stall_F, o_stall_D, o_stall_E, o_stall_M,
           o_bubble_E, o_bubble_M, o_bubble_W, o_flush_D,
           o_mc_busy, o_stall_cnt
  );

endinterface

// File: rtl/hzd_ctrl_sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt -- saturating up-counter for performance counters.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_inc   : count this edge
//   o_count : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/hzd_ctrl.sv
// ---------------------------------------------------------------------------
// hzd_ctrl -- pipeline hazard controller for the 5-stage core (F D E M W).
// Handles the hazards forwarding cannot: load-use, multi-cycle EX ops,
// data-memory wait and taken-branch squash.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : hzd_ctrl_if.slave
//     inputs : D sources/use flags, E rd/write/load, mc start/done,
//              mem busy, branch taken
//     outputs: stall F/D/E/M, bubble E/M/W, flush D, mc busy, stall count
// All controls are combinational from the inputs and the registered state.
// Priority: mem_busy > multi-cycle > branch > load-use.
// ---------------------------------------------------------------------------
module hzd_ctrl
  import cbl_pkg::*;
#(
  parameter int REG_SELECT   = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  hzd_ctrl_if.slave   bus
);

  hzd_state_t           state_d,     state_q;
  logic [BUB_CNT_W-1:0] bub_cnt_d,   bub_cnt_q;
  logic                 done_seen_d, done_seen_q;
  hzd_ctrl_t            ctrl;
  logic                 load_use;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = 1'b0;
    if (bus.i_is_load_E && bus.i_is_write_E &&
        (bus.i_reg_c_select_E != REG_SELECT'(REG_ZERO))) begin
      load_use = (bus.i_use_a_D && (bus.i_reg_a_select_D == bus.i_reg_c_select_E)) ||
                 (bus.i_use_b_D && (bus.i_reg_b_select_D == bus.i_reg_c_select_E));
    end
  end

  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    bub_cnt_d   = bub_cnt_q;
    done_seen_d = done_seen_q;

    if (bus.i_mem_busy) begin
      // Whole-pipe freeze: W gets a bubble because M cannot deliver a result.
      ctrl.stall_f  = 1'b1;
      ctrl.stall_d  = 1'b1;
      ctrl.stall_e  = 1'b1;
      ctrl.stall_m  = 1'b1;
      ctrl.bubble_w = 1'b1;
      // Remember a done pulse that lands during the freeze.
      if ((state_q == MC_WAIT) && bus.i_mc_done) begin
        done_seen_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.i_mc_start_E && !bus.i_mc_done) begin
            ctrl.stall_f  = 1'b1;
            ctrl.stall_d  = 1'b1;
            ctrl.stall_e  = 1'b1;
            ctrl.bubble_m = 1'b1;
            state_d       = MC_WAIT;
          end else if (bus.i_mc_start_E) begin
            // Result ready in the start cycle: nothing to hold.
          end else if (bus.i_branch_taken_E) begin
            // The D instruction is squashed, so its load-use hazard is moot.
            ctrl.flush_d  = 1'b1;
            ctrl.bubble_e = 1'b1;
          end else if (load_use) begin
            ctrl.stall_f  = 1'b1;
            ctrl.stall_d  = 1'b1;
            ctrl.bubble_e = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bub_cnt_d = BUB_CNT_W'(LOAD_BUBBLES - 1);
              state_d   = LOAD_WAIT;
            end
          end
        end

        LOAD_WAIT: begin
          ctrl.stall_f  = 1'b1;
          ctrl.stall_d  = 1'b1;
          ctrl.bubble_e = 1'b1;
          bub_cnt_d     = bub_cnt_q - 1'b1;
          if (bub_cnt_q == BUB_CNT_W'(1)) begin
            state_d = RUN;
          end
        end

        MC_WAIT: begin
          if (bus.i_mc_done || done_seen_q) begin
            done_seen_d = 1'b0;
            state_d     = RUN;
          end else begin
            ctrl.stall_f  = 1'b1;
            ctrl.stall_d  = 1'b1;
            ctrl.stall_e  = 1'b1;
            ctrl.bubble_m = 1'b1;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      bub_cnt_q   <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bub_cnt_q   <= bub_cnt_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign bus.o_stall_F  = ctrl.stall_f;
  assign bus.o_stall_D  = ctrl.stall_d;
  assign bus.o_stall_E  = ctrl.stall_e;
  assign bus.o_stall_M  = ctrl.stall_m;
  assign bus.o_bubble_E = ctrl.bubble_e;
  assign bus.o_bubble_M = ctrl.bubble_m;
  assign bus.o_bubble_W = ctrl.bubble_w;
  assign bus.o_flush_D  = ctrl.flush_d;
  assign bus.o_mc_busy  = (state_q == MC_WAIT);

  sat_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (ctrl.stall_f),
    .o_count (bus.o_stall_cnt)
  );

endmodule

// File: tb/tb_hzd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hzd_ctrl -- directed bench for hzd_ctrl.
//   u1 : LOAD_BUBBLES=1, CNT_WIDTH=32  (vector table, mc sequences)
//   u3 : LOAD_BUBBLES=3, CNT_WIDTH=32  (multi-bubble load-use, reset mid-wait)
//   u4 : LOAD_BUBBLES=1, CNT_WIDTH=4   (counter saturation)
// Output word: {stall_F,stall_D,stall_E,stall_M,bubble_E,bubble_M,bubble_W,
//               flush_D,mc_busy}
// ---------------------------------------------------------------------------
module tb_hzd_ctrl;

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] BR   = 9'b000010010;
  localparam logic [8:0] FRZ  = 9'b111100100;
  localparam logic [8:0] MCS  = 9'b111001000;
  localparam logic [8:0] MCW  = 9'b111001001;
  localparam logic [8:0] FRZB = 9'b111100101;
  localparam logic [8:0] RELB = 9'b000000001;

  typedef struct {
    string      name;
    logic [4:0] ra, rb;
    logic       ua, ub, wr, ld;
    logic [4:0] rc;
    logic       mcs, mcd, mb, br;
    logic [8:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hzd_ctrl_if #(.REG_SELECT(5), .CNT_WIDTH(32)) b1 ();
  hzd_ctrl_if #(.REG_SELECT(5), .CNT_WIDTH(32)) b3 ();
  hzd_ctrl_if #(.REG_SELECT(5), .CNT_WIDTH(4))  b4 ();

  hzd_ctrl #(.REG_SELECT(5), .LOAD_BUBBLES(1), .CNT_WIDTH(32)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave));
  hzd_ctrl #(.REG_SELECT(5), .LOAD_BUBBLES(3), .CNT_WIDTH(32)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b3.slave));
  hzd_ctrl #(.REG_SELECT(5), .LOAD_BUBBLES(1), .CNT_WIDTH(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic [4:0] ra, logic [4:0] rb,
                              logic ua, logic ub, logic wr, logic ld,
                              logic [4:0] rc, logic mcs, logic mcd,
                              logic mb, logic br, logic [8:0] exp);
    vec_t v;
    v.name = name; v.ra = ra; v.rb = rb; v.ua = ua; v.ub = ub;
    v.wr = wr; v.ld = ld; v.rc = rc; v.mcs = mcs; v.mcd = mcd;
    v.mb = mb; v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] out1();
    return {b1.o_stall_F, b1.o_stall_D, b1.o_stall_E, b1.o_stall_M,
            b1.o_bubble_E, b1.o_bubble_M, b1.o_bubble_W, b1.o_flush_D,
            b1.o_mc_busy};
  endfunction

  function automatic logic [8:0] out3();
    return {b3.o_stall_F, b3.o_stall_D, b3.o_stall_E, b3.o_stall_M,
            b3.o_bubble_E, b3.o_bubble_M, b3.o_bubble_W, b3.o_flush_D,
            b3.o_mc_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    b1.i_reg_a_select_D = v.ra;
    b1.i_reg_b_select_D = v.rb;
    b1.i_use_a_D        = v.ua;
    b1.i_use_b_D        = v.ub;
    b1.i_is_write_E     = v.wr;
    b1.i_is_load_E      = v.ld;
    b1.i_reg_c_select_E = v.rc;
    b1.i_mc_start_E     = v.mcs;
    b1.i_mc_done        = v.mcd;
    b1.i_mem_busy       = v.mb;
    b1.i_branch_taken_E = v.br;
  endtask

  // Load rd=5 in E against D rs1=5 when hz=1, otherwise idle.
  task automatic drive3(input logic hz);
    b3.i_reg_a_select_D = 5'd5;
    b3.i_reg_b_select_D = 5'd0;
    b3.i_use_a_D        = hz;
    b3.i_use_b_D        = 1'b0;
    b3.i_is_write_E     = hz;
    b3.i_is_load_E      = hz;
    b3.i_reg_c_select_E = 5'd5;
    b3.i_mc_start_E     = 1'b0;
    b3.i_mc_done        = 1'b0;
    b3.i_mem_busy       = 1'b0;
    b3.i_branch_taken_E = 1'b0;
  endtask

  task automatic drive4(input logic mb);
    b4.i_reg_a_select_D = 5'd0;
    b4.i_reg_b_select_D = 5'd0;
    b4.i_use_a_D        = 1'b0;
    b4.i_use_b_D        = 1'b0;
    b4.i_is_write_E     = 1'b0;
    b4.i_is_load_E      = 1'b0;
    b4.i_reg_c_select_E = 5'd0;
    b4.i_mc_start_E     = 1'b0;
    b4.i_mc_done        = 1'b0;
    b4.i_mem_busy       = mb;
    b4.i_branch_taken_E = 1'b0;
  endtask

  // Advance one full cycle: inputs are driven at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  vec_t vecs[12];
  vec_t idle;
  vec_t v;

  initial begin
    errors = 0;
    checks = 0;
    idle = mk("idle", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, NONE);

    vecs[0]  = mk("idle",         5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, NONE);
    vecs[1]  = mk("lu_rs1",       5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0, 0, 0, LU);
    vecs[2]  = mk("lu_r0",        5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 0, 0, NONE);
    vecs[3]  = mk("lu_rs2",       5'd3, 5'd9, 0, 1, 1, 1, 5'd9, 0, 0, 0, 0, LU);
    vecs[4]  = mk("lu_no_use",    5'd5, 5'd5, 0, 0, 1, 1, 5'd5, 0, 0, 0, 0, NONE);
    vecs[5]  = mk("lu_no_write",  5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0, 0, 0, NONE);
    vecs[6]  = mk("alu_not_load", 5'd5, 5'd0, 1, 0, 1, 0, 5'd5, 0, 0, 0, 0, NONE);
    vecs[7]  = mk("br_beats_lu",  5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0, 0, 1, BR);
    vecs[8]  = mk("mem_frz_lu",   5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0, 1, 0, FRZ);
    vecs[9]  = mk("mc_same_cyc",  5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 1, 0, 1, NONE);
    vecs[10] = mk("mem_frz_br",   5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 1, FRZ);
    vecs[11] = mk("lu_mismatch",  5'd5, 5'd7, 1, 0, 1, 1, 5'd7, 0, 0, 0, 0, NONE);

    drive1(idle);
    drive3(1'b0);
    drive4(1'b0);
    rst_n = 1'b0;
    cyc();
    #1;
    chk("reset_out1", 32'(out1()), 32'(NONE));
    chk("reset_cnt1", b1.o_stall_cnt, 32'd0);
    chk("reset_out3", 32'(out3()), 32'(NONE));
    rst_n = 1'b1;
    cyc();

    // Single-cycle combinational vectors; every one leaves u1 in RUN.
    for (int i = 0; i < 12; i++) begin
      drive1(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(out1()), 32'(vecs[i].exp));
      cyc();
    end
    drive1(idle);
    chk("table_cnt", b1.o_stall_cnt, 32'd4);

    // Load-use with one bubble: stall exactly one cycle.
    reset_all();
    v = idle; v.ra = 5'd5; v.ua = 1; v.wr = 1; v.ld = 1; v.rc = 5'd5;
    drive1(v);
    #1 chk("lu1_c0", 32'(out1()), 32'(LU));
    cyc();
    drive1(idle);
    #1 chk("lu1_c1", 32'(out1()), 32'(NONE));
    cyc();
    chk("lu1_cnt", b1.o_stall_cnt, 32'd1);

    // Multi-cycle op, done arrives 4 cycles after start.
    reset_all();
    v = idle; v.mcs = 1;
    drive1(v);
    #1 chk("mc_c0", 32'(out1()), 32'(MCS));
    for (int k = 1; k < 4; k++) begin
      cyc();
      #1 chk("mc_wait", 32'(out1()), 32'(MCW));
    end
    cyc();
    v.mcd = 1;
    drive1(v);
    #1 chk("mc_done", 32'(out1()), 32'(RELB));
    cyc();
    drive1(idle);
    #1 chk("mc_after", 32'(out1()), 32'(NONE));
    chk("mc_cnt", b1.o_stall_cnt, 32'd4);

    // Done pulse hidden under a memory freeze must still release the stall.
    reset_all();
    v = idle; v.mcs = 1;
    drive1(v);
    #1 chk("fd_c0", 32'(out1()), 32'(MCS));
    cyc();
    v.mb = 1; v.mcd = 1;
    drive1(v);
    #1 chk("fd_done_frz", 32'(out1()), 32'(FRZB));
    cyc();
    v.mcd = 0;
    drive1(v);
    #1 chk("fd_frz", 32'(out1()), 32'(FRZB));
    cyc();
    v.mb = 0;
    drive1(v);
    #1 chk("fd_release", 32'(out1()), 32'(RELB));
    cyc();
    drive1(idle);
    #1 chk("fd_after", 32'(out1()), 32'(NONE));
    chk("fd_cnt", b1.o_stall_cnt, 32'd3);

    // Three load-use bubbles.
    reset_all();
    drive3(1'b1);
    #1 chk("lu3_c0", 32'(out3()), 32'(LU));
    cyc();
    drive3(1'b0);
    #1 chk("lu3_c1", 32'(out3()), 32'(LU));
    cyc();
    #1 chk("lu3_c2", 32'(out3()), 32'(LU));
    cyc();
    #1 chk("lu3_c3", 32'(out3()), 32'(NONE));
    chk("lu3_cnt", b3.o_stall_cnt, 32'd3);

    // Asynchronous reset while in LOAD_WAIT.
    drive3(1'b1);
    cyc();
    drive3(1'b0);
    #1 chk("rst_pre", 32'(out3()), 32'(LU));
    rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(out3()), 32'(NONE));
    chk("rst_cnt", b3.o_stall_cnt, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    #1 chk("rst_after", 32'(out3()), 32'(NONE));

    // 4-bit counter saturates under a long memory freeze.
    drive4(1'b1);
    repeat (10) cyc();
    chk("sat_cnt10", 32'(b4.o_stall_cnt), 32'd10);
    repeat (10) cyc();
    chk("sat_cnt20", 32'(b4.o_stall_cnt), 32'd15);
    drive4(1'b0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
